md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameter TAG_W, 5, width of request/response tag.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 flush_in  in  1  pipeline flush; aborts current operation.
REQ-005 req_valid  in  1  pipeline offers an HI/LO operation.
REQ-006 req_ready  out  1  block accepts the request this cycle.
REQ-007 req_op  in  4  operation code (package encoding).
REQ-008 req_a, req_b  in  32 each  operands.
REQ-009 req_tag  in  TAG_W  destination tag, returned with MFHI/MFLO data.
REQ-010 resp_valid  out  1  read data valid; held until accepted.
REQ-011 resp_ready  in  1  pipeline accepts the response.
REQ-012 resp_data  out  32  HI or LO value.
REQ-013 resp_tag  out  TAG_W  tag of the read request.
REQ-014 md_op  out  4  operation code to the multiply/divide unit (multdiv).
REQ-015 md_a, md_b  out  32 each  operands to multdiv.
REQ-016 md_flush  out  1  flush to multdiv.
REQ-017 md_c  in  32  multdiv read result; combinational on md_op.
REQ-018 md_busy  in  1  multdiv busy.
REQ-019 pending  out  1  high in any state other than IDLE.

Function
REQ-020 Op codes SHALL be NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; codes 9-15 are illegal.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-022 req_ready SHALL be high only in IDLE with flush_in low; a transfer occurs when req_valid and req_ready are both high.
REQ-023 On transfer, op, a, b and tag SHALL be registered, and the FSM SHALL move to ISSUE; an illegal op SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-024 In ISSUE, md_op, md_a and md_b SHALL present the registered values for exactly one cycle; in all other states they SHALL be NONE/0/0.
REQ-025 From ISSUE: MULT/MULTU/DIV/DIVU SHALL go to WAIT; MTHI/MTLO SHALL go to IDLE; MFHI/MFLO SHALL capture md_c and the tag into the response registers and go to RESP.
REQ-026 In WAIT, the FSM SHALL remain while md_busy=1 and SHALL go to IDLE on the first cycle md_busy=0, with the entry cycle excluded because busy rises one cycle after issue.
REQ-027 Issue-to-IDLE latency SHALL be 7 cycles for MULT/MULTU (busy high 5 cycles) and 12 for DIV/DIVU (busy high 10).
REQ-028 In RESP, resp_valid SHALL be 1 and resp_data/resp_tag SHALL be stable; on resp_ready=1 the FSM SHALL go to IDLE.
REQ-029 md_flush SHALL equal flush_in combinationally.
REQ-030 flush_in=1 in any state SHALL force IDLE next cycle and clear resp_valid; a multiply or divide in ISSUE or WAIT is abandoned with HI/LO unchanged.
REQ-031 flush_in has priority over req_valid, resp_ready and md_busy in the same cycle.
REQ-032 Back-to-back requests SHALL be accepted no sooner than the cycle after return to IDLE; there is no overlap.

Reset
REQ-033 reset SHALL force IDLE; clear the registered op, operands, tag and response; and drive outputs req_ready=0 in the reset cycle, resp_valid=0, pending=0, md_op=NONE, md_a=md_b=0.
REQ-034 Reset mid-WAIT SHALL not wait for md_busy; multdiv is reset by the same signal.

Structure
REQ-035 Op codes, the FSM state encoding and TAG_W default SHALL live in shared package md_pkg, also used by multdiv.
REQ-036 No sub-module is needed; the response register SHALL be inline.

Verification
REQ-037 MULT a=0xFFFFFFFF b=2, then MFLO and MFHI -> resp_data=0xFFFFFFFE and then 0xFFFFFFFF (signed -2 gives HI=0xFFFFFFFF); MULT issue-to-IDLE = 7 cycles.
REQ-038 DIVU a=7 b=2, then MFLO tag=3 and MFHI tag=4 -> responses 3 with tag 3 and 1 with tag 4; DIVU issue-to-IDLE = 12 cycles.
REQ-039 MTHI a=0x1234, then MFHI -> resp_data=0x1234; no response for MTHI.
REQ-040 Prior LO=5, then DIV 100/7 with flush_in in the 3rd WAIT cycle, then MFLO -> IDLE next cycle, md_flush pulse, resp_data=5.
REQ-041 MFLO with resp_ready low for 3 cycles -> resp_valid and resp_data stable and req_ready=0 throughout; IDLE the cycle after resp_ready=1.
REQ-042 Reset asserted during WAIT of MULTU, and req_valid with flush_in in IDLE -> IDLE next cycle, all outputs at reset values, and no transfer on the flush cycle.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: op codes, issue FSM encoding and tag width shared by md_issue_ctrl and multdiv
package md_pkg;
  localparam int TAG_W_DEF = 5;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} md_state_e;
  function automatic logic op_legal(logic [3:0] op);
    return op <= 4'(OP_MTLO);
  endfunction
  function automatic logic op_long(logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
  function automatic logic op_read(logic [3:0] op);
    return op inside {OP_MFHI, OP_MFLO};
  endfunction
endpackage

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: sequences one HI/LO operation at a time into multdiv and returns MFHI/MFLO data
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [3:0]       md_op,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  output logic             md_flush,
  input  logic [31:0]      md_c,
  input  logic             md_busy,
  output logic             pending
);
  md_state_e state, state_n;
  logic [3:0] op_q;
  logic [31:0] a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic first_q;
  logic take;
  always_comb begin
    req_ready = state == S_IDLE && !flush_in && !reset;
    take = req_valid && req_ready && op_legal(req_op);
    md_op = state == S_ISSUE ? op_q : 4'(OP_NONE);
    md_a = state == S_ISSUE ? a_q : '0;
    md_b = state == S_ISSUE ? b_q : '0;
    md_flush = flush_in;
    pending = state != S_IDLE;
    resp_valid = state == S_RESP;
    state_n = state;
    // busy only rises the cycle after issue, so the first WAIT cycle ignores it
    if (flush_in) state_n = S_IDLE;
    else
      case (state)
        S_IDLE:  state_n = take ? S_ISSUE : S_IDLE;
        S_ISSUE: state_n = op_long(op_q) ? S_WAIT : op_read(op_q) ? S_RESP : S_IDLE;
        S_WAIT:  state_n = !first_q && !md_busy ? S_IDLE : S_WAIT;
        default: state_n = resp_ready ? S_IDLE : S_RESP;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      first_q <= 1'b0;
      resp_data <= '0;
      resp_tag <= '0;
    end else begin
      state <= state_n;
      first_q <= state == S_ISSUE;
      if (take) begin
        op_q <= req_op;
        a_q <= req_a;
        b_q <= req_b;
        tag_q <= req_tag;
      end
      if (state == S_ISSUE && op_read(op_q) && !flush_in) begin
        resp_data <= md_c;
        resp_tag <= tag_q;
      end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: multdiv stand-in plus transaction-level reference for md_issue_ctrl
module tb_md_issue_ctrl;
  import md_pkg::*;
  localparam int TW = TAG_W_DEF;
  logic clk = 0, reset = 1, flush_in = 0, req_valid = 0, resp_ready = 0;
  logic [3:0] req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic [TW-1:0] req_tag = 0;
  logic req_ready, resp_valid, md_flush, md_busy, pending;
  logic [31:0] resp_data, md_a, md_b, md_c;
  logic [TW-1:0] resp_tag;
  logic [3:0] md_op;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .md_flush(md_flush), .md_c(md_c), .md_busy(md_busy), .pending(pending)
  );

  function automatic logic [63:0] calc(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sp;
    int q, r;
    case (op)
      4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      4'd2: return {32'h0, a} * {32'h0, b};
      4'd3: begin
        if (b == 0) return {a, 32'hffffffff};
        if (a == 32'h80000000 && b == 32'hffffffff) return {32'h0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      4'd4: return b == 0 ? {a, 32'hffffffff} : {a % b, a / b};
      default: return 64'h0;
    endcase
  endfunction

  function automatic int lat(logic [3:0] op);
    return (op == 4'd1 || op == 4'd2) ? 7 : (op == 4'd3 || op == 4'd4) ? 12 : 1;
  endfunction

  // multdiv stand-in: busy 5 (mul) or 10 (div) cycles starting the cycle after issue
  logic [31:0] hi = 0, lo = 0, phi = 0, plo = 0;
  int cnt = 0;
  assign md_busy = cnt != 0;
  assign md_c = md_op == 4'd5 ? hi : md_op == 4'd6 ? lo : 32'h0;
  always @(posedge clk)
    if (reset) begin
      hi <= 0; lo <= 0; cnt <= 0;
    end else if (md_flush) cnt <= 0;
    else begin
      if (cnt == 1) begin hi <= phi; lo <= plo; end
      if (cnt != 0) cnt <= cnt - 1;
      if (md_op >= 4'd1 && md_op <= 4'd4) begin
        {phi, plo} <= calc(md_op, md_a, md_b);
        cnt <= md_op <= 4'd2 ? 5 : 10;
      end
      if (md_op == 4'd7) hi <= md_a;
      if (md_op == 4'd8) lo <= md_a;
    end

  // reference: k counts cycles since acceptance (1 = issue cycle), rsp marks a held response
  int k = 0;
  bit rsp = 0, go = 0;
  logic [3:0] mop = 0;
  logic [31:0] ma = 0, mb = 0, rhi = 0, rlo = 0, ed = 0;
  logic [TW-1:0] mt = 0, et = 0;
  always @(posedge clk)
    if (reset) begin
      k <= 0; rsp <= 0; rhi <= 0; rlo <= 0; go <= 1;
    end else if (flush_in) begin
      k <= 0; rsp <= 0;
    end else if (k == 0) begin
      if (!rsp && req_valid && req_op <= 4'd8) begin
        k <= 1; mop <= req_op; ma <= req_a; mb <= req_b; mt <= req_tag;
      end
      if (rsp && resp_ready) rsp <= 0;
    end else begin
      if (lat(mop) > 1 && k == lat(mop) - 1) {rhi, rlo} <= calc(mop, ma, mb);
      if (mop == 4'd7) rhi <= ma;
      if (mop == 4'd8) rlo <= ma;
      if (mop == 4'd5 || mop == 4'd6) begin
        rsp <= 1; ed <= mop == 4'd5 ? rhi : rlo; et <= mt;
      end
      k <= k == lat(mop) ? 0 : k + 1;
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (go) begin
      chk("req_ready", req_ready, !reset && k == 0 && !rsp && !flush_in);
      chk("pending", pending, k != 0 || rsp);
      chk("resp_valid", resp_valid, rsp);
      chk("md_op", md_op, k == 1 ? mop : 4'd0);
      chk("md_a", md_a, k == 1 ? ma : 32'd0);
      chk("md_b", md_b, k == 1 ? mb : 32'd0);
      chk("md_flush", md_flush, flush_in);
      if (rsp) begin
        chk("resp_data", resp_data, ed);
        chk("resp_tag", resp_tag, et);
      end
    end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [TW-1:0] tag);
    int n = 0;
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("send_accepted", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (pending && cyc < 40) begin cyc++; @(negedge clk); end
    @(posedge clk); #1;
  endtask

  task automatic get_resp(logic [31:0] d, logic [TW-1:0] t, int hold);
    int n = 0;
    resp_ready = 0;
    @(negedge clk);
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    chk("resp_seen", resp_valid, 1);
    chk("resp_data_lit", resp_data, d);
    chk("resp_tag_lit", resp_tag, t);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, d);
      chk("hold_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    @(negedge clk);
    chk("idle_after_resp", pending, 0);
    @(posedge clk); #1;
  endtask

  int c;
  initial begin
    step(2);
    reset = 0;
    @(negedge clk);
    chk("rst_pending", pending, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_md_op", md_op, 0);
    chk("rst_req_ready", req_ready, 1);
    step(1);
    send(OP_MULT, 32'hffffffff, 32'd2, 5'd1);
    wait_idle(c);
    chk("mult_latency", c, 7);
    send(OP_MFLO, 0, 0, 5'd2);
    get_resp(32'hfffffffe, 5'd2, 0);
    send(OP_MFHI, 0, 0, 5'd5);
    get_resp(32'hffffffff, 5'd5, 0);
    send(OP_DIVU, 32'd7, 32'd2, 5'd0);
    wait_idle(c);
    chk("divu_latency", c, 12);
    send(OP_MFLO, 0, 0, 5'd3);
    get_resp(32'd3, 5'd3, 0);
    send(OP_MFHI, 0, 0, 5'd4);
    get_resp(32'd1, 5'd4, 0);
    send(OP_MTHI, 32'h1234, 0, 5'd0);
    wait_idle(c);
    chk("mthi_latency", c, 1);
    chk("mthi_no_resp", resp_valid, 0);
    send(OP_MFHI, 0, 0, 5'd6);
    get_resp(32'h1234, 5'd6, 0);
    send(OP_MTLO, 32'd5, 0, 5'd0);
    wait_idle(c);
    send(OP_DIV, 32'd100, 32'd7, 5'd0);
    step(3);
    flush_in = 1;
    @(negedge clk);
    chk("md_flush_pulse", md_flush, 1);
    @(posedge clk); #1;
    flush_in = 0;
    @(negedge clk);
    chk("flush_idle", pending, 0);
    step(1);
    send(OP_MFLO, 0, 0, 5'd7);
    get_resp(32'd5, 5'd7, 3);
    send(4'd12, 32'd9, 32'd9, 5'd0);
    @(negedge clk);
    chk("illegal_dropped", pending, 0);
    step(1);
    send(OP_MULTU, 32'd3, 32'd4, 5'd0);
    step(2);
    reset = 1;
    @(negedge clk);
    chk("reset_cycle_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_md_op", md_op, 0);
    chk("post_rst_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1; req_op = OP_MULT; flush_in = 1;
    @(negedge clk);
    chk("flush_blocks_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 0; flush_in = 0;
    @(negedge clk);
    chk("no_xfer_on_flush", pending, 0);
    step(1);
    send(OP_MFLO, 0, 0, 5'd9);
    get_resp(32'd0, 5'd9, 0);
    repeat (4000) begin
      reset = $urandom_range(0, 199) == 0;
      flush_in = $urandom_range(0, 39) == 0;
      req_valid = 1'($urandom_range(0, 1));
      req_op = $urandom_range(0, 9) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8));
      req_a = $urandom;
      req_b = $urandom_range(0, 3) == 0 ? $urandom_range(0, 9) : $urandom;
      req_tag = TW'($urandom);
      resp_ready = $urandom_range(0, 2) == 0;
      step(1);
    end
    reset = 0; flush_in = 0; req_valid = 0; resp_ready = 1;
    step(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
